uart_fifo: RTL and testbench
============================

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: frame data width, legal 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: TX and RX FIFO depth each, power of two, 2..256.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits transmitted, legal 1 or 2.
REQ-004 SHALL have port clock  input  1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port tx  output  1: serial transmit line, idle high.
REQ-007 SHALL have port rx  input  1: serial receive line, asynchronous to clock.
REQ-008 SHALL have port tx_data  input  8: byte to push into TX FIFO; bits above DATA_BITS-1 ignored.
REQ-009 SHALL have port write_new_tx_data  input  1: one-cycle push strobe for tx_data.
REQ-010 SHALL have port rx_data  output  8: RX FIFO head (first-word fall-through), zero-extended above DATA_BITS.
REQ-011 SHALL have port read_last_rx_data  input  1: one-cycle pop strobe for RX FIFO head.
REQ-012 SHALL have port baud_divider  input  16: clocks per bit; values 0 and 1 treated as 2.
REQ-013 SHALL have port control_register  input  8: [0] tx_enable, [1] rx_enable, [2] parity_odd, [3] parity_en, [4] tx_flush, [5] rx_flush, [7] error_clear.
REQ-014 SHALL have port status_register  output  8: [0] tx_busy, [1] rx_not_empty, [2] rx_busy, [3] tx_full, [4] rx_full, [5] framing_error, [6] parity_error, [7] overrun.

Function
REQ-015 SHALL push into TX FIFO when write_new_tx_data=1 and not full; push while full SHALL be dropped, FIFO unchanged.
REQ-016 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE->START when tx_enable=1 and TX FIFO non-empty, popping head in that cycle.
REQ-017 Each TX bit SHALL last exactly baud_divider clocks; order: start (0), DATA_BITS LSB first, parity (if enabled), STOP_BITS ones.
REQ-018 After last stop bit SHALL go directly to START if FIFO non-empty and tx_enable=1 (no idle gap), else IDLE.
REQ-019 tx_enable deasserted mid-frame SHALL complete current frame, then hold IDLE.
REQ-020 tx_busy SHALL be 1 from START through final stop bit, 0 in IDLE.
REQ-021 rx SHALL pass through a 2-flop synchronizer; all RX decisions use synchronized value.
REQ-022 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronized falling edge when rx_enable=1.
REQ-023 START SHALL resample at baud_divider/2 clocks; if line high, SHALL return to IDLE (glitch reject), no flags.
REQ-024 Subsequent bits SHALL be sampled every baud_divider clocks from the start midpoint; only first stop bit checked.
REQ-025 Stop bit 0 SHALL set framing_error and discard byte; parity mismatch SHALL set parity_error and discard byte.
REQ-026 Valid byte with RX FIFO full SHALL set overrun and discard byte; FIFO contents preserved.
REQ-027 read_last_rx_data SHALL pop head; pop on empty ignored; simultaneous push and pop SHALL both take effect, count unchanged.
REQ-028 rx_enable deasserted mid-frame SHALL abort to IDLE with no push.
REQ-029 Error flags SHALL be sticky; error_clear=1 clears all three, taking priority over a same-cycle set.
REQ-030 tx_flush=1 SHALL empty TX FIFO (frame in flight completes); rx_flush=1 SHALL empty RX FIFO.

Reset
REQ-031 reset=1 SHALL immediately force tx=1, both FSMs IDLE, both FIFOs empty, baud counters 0, status_register=0x00, rx_data=0x00.
REQ-032 Reset mid-frame SHALL abandon the frame; no partial byte SHALL enter RX FIFO after release.

Configuration
REQ-033 Macro UART_FIFO_PARITY_EN defined: PARITY state present; parity_en/parity_odd honoured; even parity = XOR of data bits, odd = inverted.
REQ-034 Macro UART_FIFO_PARITY_EN undefined: no parity logic; control bits [2],[3] ignored; status[6] constant 0.

Verification
REQ-035 DATA_BITS=8, divider=4, no parity, push 0xA5 -> tx: 0 for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), 1 for 4 clocks; tx_busy high 40 clocks.
REQ-036 tx_enable=0, 17 pushes -> tx_full=1 after 16th, 17th dropped; enable -> exactly 16 back-to-back frames.
REQ-037 tx looped to rx, divider=8, send 0x3C,0xC3 -> rx_not_empty=1, rx_data=0x3C, pop -> 0xC3, pop -> rx_not_empty=0.
REQ-038 Drive rx frame 0x55 with stop bit 0 -> framing_error=1, RX FIFO empty; error_clear pulse -> status[5]=0.
REQ-039 Macro defined, parity_en=1, parity_odd=1, frame 0x01 with parity bit 1 -> parity_error=1, byte discarded; parity bit 0 -> byte 0x01 accepted.
REQ-040 Fill RX FIFO to 16, send 0x77 -> overrun=1, FIFO head unchanged; assert reset mid-TX frame -> tx=1 same cycle, status 0x00.

Source files
------------

// File: rtl/uart_fifo.sv
// UART with TX/RX FWFT FIFOs, programmable baud divider and sticky error flags.
// Parity support is compiled in only when UART_FIFO_PARITY_EN is defined.
module uart_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        tx,
    input  logic        rx,
    input  logic [7:0]  tx_data,
    input  logic        write_new_tx_data,
    output logic [7:0]  rx_data,
    input  logic        read_last_rx_data,
    input  logic [15:0] baud_divider,
    input  logic [7:0]  control_register,
    output logic [7:0]  status_register
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_FIFO_PARITY_EN
        , PARITY
`endif
    } state_t;

    genvar gi;

    logic tx_enable, rx_enable, tx_flush, rx_flush, error_clear;
    logic parity_en, parity_odd;
    assign tx_enable   = control_register[0];
    assign rx_enable   = control_register[1];
    assign tx_flush    = control_register[4];
    assign rx_flush    = control_register[5];
    assign error_clear = control_register[7];
`ifdef UART_FIFO_PARITY_EN
    assign parity_odd  = control_register[2];
    assign parity_en   = control_register[3];
    logic unused_bits;
    assign unused_bits = &{1'b0, control_register[6], tx_data};
`else
    assign parity_odd  = 1'b0;
    assign parity_en   = 1'b0;
    logic unused_bits;
    assign unused_bits = &{1'b0, control_register[6], control_register[3:2], tx_data};
`endif

    logic [15:0] baud_eff;
    assign baud_eff = (baud_divider < 16'd2) ? 16'd2 : baud_divider;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [CW-1:0]        tx_count_reg;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_full  = (tx_count_reg == DEPTH_C);
    assign tx_empty = (tx_count_reg == '0);
    assign tx_push  = write_new_tx_data && !tx_full;
    assign tx_head  = tx_mem[tx_rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg] <= tx_data[DATA_BITS-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + AW'(1);
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + AW'(1);
            if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + CW'(1);
            else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - CW'(1);
        end
    end

    // ---------------- TX FSM ----------------
    state_t               tx_state_reg, tx_state_next;
    logic [15:0]          tx_cnt_reg, tx_cnt_next;
    logic [2:0]           tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_load, tx_line, tx_bit_end;
`ifdef UART_FIFO_PARITY_EN
    logic                 tx_par_reg, tx_par_next;
`endif

    assign tx_bit_end = (tx_cnt_reg == baud_eff - 16'd1);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_bit_end ? 16'd0 : tx_cnt_reg + 16'd1;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
`ifdef UART_FIFO_PARITY_EN
        tx_par_next   = tx_par_reg;
`endif
        tx_load       = 1'b0;
        tx_line       = 1'b1;
        case (tx_state_reg)
            IDLE: begin
                tx_cnt_next = '0;
                tx_load     = tx_enable && !tx_empty;
            end
            START: begin
                tx_line = 1'b0;
                if (tx_bit_end) begin
                    tx_state_next = DATA;
                    tx_bit_next   = '0;
                end
            end
            DATA: begin
                tx_line = tx_shift_reg[0];
                if (tx_bit_end) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    tx_bit_next   = tx_bit_reg + 3'd1;
                    if (tx_bit_reg == LAST_DATA) begin
                        tx_bit_next   = '0;
`ifdef UART_FIFO_PARITY_EN
                        tx_state_next = parity_en ? PARITY : STOP;
`else
                        tx_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_FIFO_PARITY_EN
            PARITY: begin
                tx_line = tx_par_reg;
                if (tx_bit_end) tx_state_next = STOP;
            end
`endif
            STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_reg == LAST_STOP) begin
                        tx_state_next = IDLE;
                        tx_load       = tx_enable && !tx_empty;
                    end else begin
                        tx_bit_next = tx_bit_reg + 3'd1;
                    end
                end
            end
            default: tx_state_next = IDLE;
        endcase
        // Loading straight from STOP gives back-to-back frames with no idle gap.
        if (tx_load) begin
            tx_state_next = START;
            tx_cnt_next   = '0;
            tx_bit_next   = '0;
            tx_shift_next = tx_head;
`ifdef UART_FIFO_PARITY_EN
            tx_par_next   = (^tx_head) ^ parity_odd;
`endif
        end
    end

    assign tx_pop = tx_load;
    assign tx     = tx_line;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_reg <= IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
`ifdef UART_FIFO_PARITY_EN
            tx_par_reg   <= 1'b0;
`endif
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
`ifdef UART_FIFO_PARITY_EN
            tx_par_reg   <= tx_par_next;
`endif
        end
    end

    // ---------------- RX synchronizer and FSM ----------------
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    state_t               rx_state_reg, rx_state_next;
    logic [15:0]          rx_cnt_reg, rx_cnt_next;
    logic [2:0]           rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic                 rx_bit_end, rx_mid, rx_par_bad, rx_full, rx_empty;
    logic                 rx_push, rx_pop, fe_set, pe_set, ov_set;
`ifdef UART_FIFO_PARITY_EN
    logic                 rx_par_reg, rx_par_next;
    assign rx_par_bad = parity_en && (rx_par_reg != ((^rx_shift_reg) ^ parity_odd));
`else
    assign rx_par_bad = 1'b0;
`endif

    assign rx_bit_end = (rx_cnt_reg == baud_eff - 16'd1);
    assign rx_mid     = (rx_cnt_reg == (baud_eff >> 1) - 16'd1);

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + 16'd1;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
`ifdef UART_FIFO_PARITY_EN
        rx_par_next   = rx_par_reg;
`endif
        rx_push = 1'b0;
        fe_set  = 1'b0;
        pe_set  = 1'b0;
        ov_set  = 1'b0;
        case (rx_state_reg)
            IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg) rx_state_next = START;
            end
            START: begin
                if (rx_mid) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == LAST_DATA) begin
                        rx_bit_next   = '0;
`ifdef UART_FIFO_PARITY_EN
                        rx_state_next = parity_en ? PARITY : STOP;
`else
                        rx_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_FIFO_PARITY_EN
            PARITY: begin
                if (rx_bit_end) begin
                    rx_cnt_next   = '0;
                    rx_par_next   = rx_sync_reg;
                    rx_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_next   = '0;
                    rx_state_next = IDLE;
                    if (!rx_sync_reg)   fe_set  = 1'b1;
                    else if (rx_par_bad) pe_set = 1'b1;
                    else if (rx_full)   ov_set  = 1'b1;
                    else                rx_push = 1'b1;
                end
            end
            default: rx_state_next = IDLE;
        endcase
        if (!rx_enable) begin
            rx_state_next = IDLE;
            rx_cnt_next   = '0;
            rx_push       = 1'b0;
            fe_set        = 1'b0;
            pe_set        = 1'b0;
            ov_set        = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_reg <= IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
`ifdef UART_FIFO_PARITY_EN
            rx_par_reg   <= 1'b0;
`endif
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
`ifdef UART_FIFO_PARITY_EN
            rx_par_reg   <= rx_par_next;
`endif
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [CW-1:0]        rx_count_reg;
    logic [DATA_BITS-1:0] rx_head;

    assign rx_full  = (rx_count_reg == DEPTH_C);
    assign rx_empty = (rx_count_reg == '0);
    assign rx_pop   = read_last_rx_data && !rx_empty;
    assign rx_head  = rx_mem[rx_rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (rx_push)
            rx_mem[rx_wr_ptr_reg] <= rx_shift_reg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else if (rx_flush) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + AW'(1);
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + AW'(1);
            if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + CW'(1);
            else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - CW'(1);
        end
    end

    // Head is masked while empty so stale RAM contents never reach rx_data.
    for (gi = 0; gi < 8; gi++) begin : g_rx_data
        if (gi < DATA_BITS) begin : g_bit
            assign rx_data[gi] = !rx_empty && rx_head[gi];
        end else begin : g_pad
            assign rx_data[gi] = 1'b0;
        end
    end

    // ---------------- Sticky error flags ----------------
    logic fe_reg, pe_reg, ov_reg;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fe_reg <= 1'b0;
            pe_reg <= 1'b0;
            ov_reg <= 1'b0;
        end else if (error_clear) begin
            fe_reg <= 1'b0;
            pe_reg <= 1'b0;
            ov_reg <= 1'b0;
        end else begin
            fe_reg <= fe_reg | fe_set;
            pe_reg <= pe_reg | pe_set;
            ov_reg <= ov_reg | ov_set;
        end
    end

    assign status_register = {ov_reg, pe_reg, fe_reg, rx_full, tx_full,
                              (rx_state_reg != IDLE), !rx_empty, (tx_state_reg != IDLE)};
endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: TX frames decoded from the line, RX bytes popped by a monitor.
`timescale 1ns/1ps
module tb_uart_fifo;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tx, rx_line;
    logic        rx_drive = 1'b1;
    logic        loop_en = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        write_new_tx_data = 1'b0;
    logic [7:0]  rx_data;
    logic        read_last_rx_data = 1'b0;
    logic [15:0] baud_divider = 16'd4;
    logic [7:0]  control_register = 8'h00;
    logic [7:0]  status_register;

    int   n_checks = 0;
    int   n_fail = 0;
    int   tx_frames = 0;
    int   mon_div = 4;
    bit   tx_mon_en = 1'b1;
    bit   auto_read = 1'b0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    always #5 clock = ~clock;
    assign rx_line = loop_en ? tx : rx_drive;

    uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .STOP_BITS(1)) dut (
        .clock(clock), .reset(reset), .tx(tx), .rx(rx_line),
        .tx_data(tx_data), .write_new_tx_data(write_new_tx_data),
        .rx_data(rx_data), .read_last_rx_data(read_last_rx_data),
        .baud_divider(baud_divider), .control_register(control_register),
        .status_register(status_register)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b, input bit expect_sent);
        tx_data = b;
        write_new_tx_data = 1'b1;
        tick();
        write_new_tx_data = 1'b0;
        if (expect_sent) exp_tx.push_back(b);
        $display("push tx 0x%02h (expect sent %0d)", b, expect_sent);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input bit stop_b,
                                  input bit has_par, input bit par_b, input int div);
        rx_drive = 1'b0;
        repeat (div) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drive = b[i];
            repeat (div) tick();
        end
        if (has_par) begin
            rx_drive = par_b;
            repeat (div) tick();
        end
        rx_drive = stop_b;
        repeat (div) tick();
        rx_drive = 1'b1;
        repeat (2 * div) tick();
        $display("drive rx 0x%02h stop=%0d par=%0d/%0d", b, stop_b, has_par, par_b);
    endtask

    task automatic wait_rx_drain(input int max_ticks, input string name);
        for (int i = 0; i < max_ticks && exp_rx.size() != 0; i++) tick();
        check(name, 32'(exp_rx.size()), 32'd0);
    endtask

    task automatic pulse_ctrl(input logic [7:0] bits);
        logic [7:0] base;
        base = control_register;
        control_register = base | bits;
        tick();
        control_register = base;
        tick();
    endtask

    // Decodes every frame on tx and compares it with the expected-frame queue.
    initial begin : tx_mon
        logic [7:0] b;
        logic [7:0] e;
        logic st, sp;
        forever begin
            @(negedge clock);
            if (tx_mon_en && !reset && tx === 1'b0) begin
                repeat (mon_div / 2) @(negedge clock);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clock);
                    b[i] = tx;
                end
                repeat (mon_div) @(negedge clock);
                sp = tx;
                tx_frames++;
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_frame: got unexpected 0x%02h, expected none", b);
                end else begin
                    e = exp_tx.pop_front();
                    $display("tx frame 0x%02h start=%0d stop=%0d", b, st, sp);
                    check("tx_frame", {22'd0, st, sp, b}, {22'd0, 1'b0, 1'b1, e});
                end
            end
        end
    end

    // Pops the RX FIFO whenever it is non-empty and auto_read is on.
    initial begin : rx_mon
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (auto_read && status_register[1]) begin
                if (exp_rx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_byte: got unexpected 0x%02h, expected none", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    $display("rx byte 0x%02h", rx_data);
                    check("rx_byte", 32'(rx_data), 32'(e));
                end
                read_last_rx_data = 1'b1;
                @(posedge clock);
                #1;
                read_last_rx_data = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [39:0] got;
        logic [9:0]  pat;
        int          busy_cnt;
        int          frames0;
        bit          seen;

        repeat (3) tick();
        check("reset_status", 32'(status_register), 32'h00);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        reset = 1'b0;
        control_register = 8'h03;
        tick();

        // Single 0xA5 frame at divider 4: exact waveform and busy length.
        push_tx(8'hA5, 1'b1);
        for (int w = 0; w < 20; w++) begin
            @(negedge clock);
            if (status_register[0]) break;
        end
        check("tx_busy_rise", 32'(status_register[0]), 32'd1);
        got = '0;
        got[0] = tx;
        busy_cnt = 1;
        for (int j = 1; j < 40; j++) begin
            @(negedge clock);
            got[j] = tx;
            busy_cnt += int'(status_register[0]);
        end
        @(negedge clock);
        check("tx_busy_fall", 32'(status_register[0]), 32'd0);
        check("tx_idle_high", 32'(tx), 32'd1);
        check("tx_busy_cycles", 32'(busy_cnt), 32'd40);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++)
            check($sformatf("tx_wave_bit%0d", k), 32'(got[4*k +: 4]), 32'({4{pat[k]}}));
        tick();

        // Fill TX FIFO while disabled, then release 16 back-to-back frames.
        control_register = 8'h02;
        tick();
        for (int i = 0; i < 16; i++) begin
            push_tx(8'h10 + 8'(i), 1'b1);
            if (i == 14) check("tx_full_at_15", 32'(status_register[3]), 32'd0);
        end
        check("tx_full_at_16", 32'(status_register[3]), 32'd1);
        push_tx(8'h99, 1'b0);
        check("tx_full_after_drop", 32'(status_register[3]), 32'd1);
        frames0 = tx_frames;
        control_register = 8'h03;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (status_register[0]) begin
                busy_cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("tx_b2b_busy_cycles", 32'(busy_cnt), 32'd640);
        repeat (4) tick();
        check("tx_b2b_frames", 32'(tx_frames - frames0), 32'd16);
        check("tx_sb_drain", 32'(exp_tx.size()), 32'd0);
        check("tx_full_cleared", 32'(status_register[3]), 32'd0);

        // Loopback at divider 8.
        baud_divider = 16'd8;
        mon_div = 8;
        loop_en = 1'b1;
        auto_read = 1'b1;
        exp_rx.push_back(8'h3C);
        exp_rx.push_back(8'hC3);
        push_tx(8'h3C, 1'b1);
        push_tx(8'hC3, 1'b1);
        wait_rx_drain(400, "loop_rx_drain");
        repeat (3) tick();
        check("loop_rx_empty", 32'(status_register[1]), 32'd0);
        check("loop_tx_drain", 32'(exp_tx.size()), 32'd0);
        auto_read = 1'b0;
        loop_en = 1'b0;
        tick();

        // Framing error and clear.
        drive_rx_frame(8'h55, 1'b0, 1'b0, 1'b0, 8);
        check("framing_error_set", 32'(status_register[5]), 32'd1);
        check("framing_rx_empty", 32'(status_register[1]), 32'd0);
        pulse_ctrl(8'h80);
        check("framing_error_clear", 32'(status_register[5]), 32'd0);

        // One-clock glitch: rejected, no flags, no data.
        rx_drive = 1'b0;
        tick();
        rx_drive = 1'b1;
        repeat (20) tick();
        check("glitch_reject", 32'(status_register & 8'hE6), 32'd0);

`ifdef UART_FIFO_PARITY_EN
        control_register = 8'h0F;
        tick();
        drive_rx_frame(8'h01, 1'b1, 1'b1, 1'b1, 8);
        check("parity_error_set", 32'(status_register[6]), 32'd1);
        check("parity_rx_empty", 32'(status_register[1]), 32'd0);
        pulse_ctrl(8'h80);
        check("parity_error_clear", 32'(status_register[6]), 32'd0);
        exp_rx.push_back(8'h01);
        auto_read = 1'b1;
        drive_rx_frame(8'h01, 1'b1, 1'b1, 1'b0, 8);
        wait_rx_drain(50, "parity_ok_drain");
        check("parity_ok_no_error", 32'(status_register[6]), 32'd0);
`else
        control_register = 8'h0F;
        tick();
        exp_rx.push_back(8'h01);
        auto_read = 1'b1;
        drive_rx_frame(8'h01, 1'b1, 1'b0, 1'b0, 8);
        wait_rx_drain(50, "noparity_drain");
        check("noparity_status6", 32'(status_register[6]), 32'd0);
`endif
        auto_read = 1'b0;
        control_register = 8'h03;
        tick();

        // Fill RX FIFO, overrun, then read all 16 back intact.
        for (int i = 0; i < 16; i++) drive_rx_frame(8'h80 + 8'(i), 1'b1, 1'b0, 1'b0, 8);
        check("rx_full_set", 32'(status_register[4]), 32'd1);
        check("rx_head_full", 32'(rx_data), 32'h80);
        drive_rx_frame(8'h77, 1'b1, 1'b0, 1'b0, 8);
        check("overrun_set", 32'(status_register[7]), 32'd1);
        check("overrun_head", 32'(rx_data), 32'h80);
        for (int i = 0; i < 16; i++) exp_rx.push_back(8'h80 + 8'(i));
        auto_read = 1'b1;
        wait_rx_drain(200, "overrun_drain");
        auto_read = 1'b0;
        repeat (2) tick();
        check("overrun_rx_empty", 32'(status_register[1]), 32'd0);
        pulse_ctrl(8'h80);
        check("status_idle", 32'(status_register), 32'h00);

        // RX flush.
        drive_rx_frame(8'h11, 1'b1, 1'b0, 1'b0, 8);
        drive_rx_frame(8'h22, 1'b1, 1'b0, 1'b0, 8);
        check("flush_pre_head", 32'(rx_data), 32'h11);
        pulse_ctrl(8'h20);
        check("flush_rx_empty", 32'(status_register[1]), 32'd0);
        check("flush_rx_data", 32'(rx_data), 32'h00);

        // Reset in the middle of a TX frame (and an RX frame).
        baud_divider = 16'd4;
        mon_div = 4;
        tx_mon_en = 1'b0;
        push_tx(8'h5A, 1'b0);
        for (int w = 0; w < 20; w++) begin
            @(negedge clock);
            if (status_register[0]) break;
        end
        rx_drive = 1'b0;
        repeat (6) tick();
        check("tx_low_before_reset", 32'(tx), 32'd0);
        reset = 1'b1;
        rx_drive = 1'b1;
        #1;
        check("reset_async_tx", 32'(tx), 32'd1);
        check("reset_async_status", 32'(status_register), 32'h00);
        check("reset_async_rx_data", 32'(rx_data), 32'h00);
        repeat (3) tick();
        reset = 1'b0;
        repeat (100) tick();
        check("post_reset_status", 32'(status_register), 32'h00);
        check("post_reset_rx_data", 32'(rx_data), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
